// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared types for the register-commit scoreboard
package checker_pkg;

   localparam int unsigned CHK_DATA_W = 32;
   localparam int unsigned CHK_ADDR_W = 5;
   localparam int unsigned CHK_PC_W   = 16;
   localparam int unsigned COMMIT_W   = CHK_ADDR_W + CHK_DATA_W + CHK_PC_W;

   typedef enum logic [2:0] {
      E_NONE  = 3'd0,
      E_ADDR  = 3'd1,
      E_PC    = 3'd2,
      E_DATA  = 3'd3,
      E_UNEXP = 3'd4,
      E_OVF   = 3'd5,
      E_TMO   = 3'd6
   } err_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic [CHK_ADDR_W-1:0] addr;
      logic [CHK_DATA_W-1:0] data;
      logic [CHK_PC_W-1:0]   pc;
   } commit_t;

   // Mismatch priority: a wrong destination explains everything downstream.
   function automatic err_t classify(input commit_t exp_c, input commit_t act_c);
      if (exp_c.addr != act_c.addr) return E_ADDR;
      if (exp_c.pc != act_c.pc)     return E_PC;
      if (exp_c.data != act_c.data) return E_DATA;
      return E_NONE;
   endfunction

endpackage

// File: rtl/commit_fifo.sv
// rtl/commit_fifo.sv - synchronous FIFO of expected commits, registered flags
module commit_fifo
   import checker_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                push_i,
   input  logic [COMMIT_W-1:0] wdata_i,
   input  logic                pop_i,
   output logic [COMMIT_W-1:0] rdata_o,
   output logic                full_o,
   output logic                empty_o,
   output logic                full_next_o
);

   commit_t        mem_q [DEPTH];
   logic [PTR_W:0] wr_q, wr_d;
   logic [PTR_W:0] rd_q, rd_d;
   logic           full_q, full_d;
   logic           empty_q, empty_d;
   logic           do_push, do_pop;

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_q;
   assign do_push = push_i && (!full_q || do_pop);

   always_comb begin
      wr_d    = wr_q + {{PTR_W{1'b0}}, do_push};
      rd_d    = rd_q + {{PTR_W{1'b0}}, do_pop};
      empty_d = (wr_d == rd_d);
      full_d  = (wr_d[PTR_W] != rd_d[PTR_W]) &&
                (wr_d[PTR_W-1:0] == rd_d[PTR_W-1:0]);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q[PTR_W-1:0]] <= commit_t'(wdata_i);
      end
   end

   assign rdata_o     = mem_q[rd_q[PTR_W-1:0]];
   assign full_o      = full_q;
   assign empty_o     = empty_q;
   assign full_next_o = full_d;

endmodule

// File: rtl/reg_commit_checker.sv
// rtl/reg_commit_checker.sv - in-order scoreboard of model vs DUT register commits
module reg_commit_checker
   import checker_pkg::*;
#(
   parameter int unsigned DATA_W  = CHK_DATA_W,
   parameter int unsigned ADDR_W  = CHK_ADDR_W,
   parameter int unsigned PC_W    = CHK_PC_W,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic              Clock,
   input  logic              nReset,
   input  logic              ExpValid,
   input  logic [ADDR_W-1:0] ExpAddr,
   input  logic [DATA_W-1:0] ExpData,
   input  logic [PC_W-1:0]   ExpPC,
   output logic              ExpReady,
   input  logic              ActValid,
   input  logic [ADDR_W-1:0] ActAddr,
   input  logic [DATA_W-1:0] ActData,
   input  logic [PC_W-1:0]   ActPC,
   input  logic              Drain,
   output logic [CNT_W-1:0]  MatchCnt,
   output logic [CNT_W-1:0]  ErrCnt,
   output logic              ErrPulse,
   output logic [2:0]        ErrCode,
   output logic [ADDR_W-1:0] ErrAddr,
   output logic [DATA_W-1:0] ErrExp,
   output logic [DATA_W-1:0] ErrAct,
   output logic              Done,
   output logic              Pass
);

   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0] n);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, n};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   state_t            state_q, state_d;
   logic              exp_v, act_v, exp_acc;
   logic              bypass, push, pop;
   logic              fifo_full, fifo_empty, fifo_full_next;
   logic [COMMIT_W-1:0] fifo_rdata;
   commit_t           exp_c, act_c, head_c, cmp_ref;
   err_t              cmp_code, evt_code;
   logic              cmp_err, match_evt, ovf_evt, tmo_evt;
   logic [1:0]        n_err;
   logic [ADDR_W-1:0] evt_addr;
   logic [DATA_W-1:0] evt_exp, evt_act;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              tmo_q, ovf_q, ready_q, pulse_q;
   logic [CNT_W-1:0]  match_q, err_cnt_q;
   err_t              err_code_q;
   logic [ADDR_W-1:0] err_addr_q;
   logic [DATA_W-1:0] err_exp_q, err_act_q;

   // Register 0 writes are architecturally invisible, so they never enter the scoreboard.
   assign exp_v   = ExpValid && (ExpAddr != '0);
   assign act_v   = ActValid && (ActAddr != '0);
   assign exp_acc = exp_v && (state_q == RUN);

   assign exp_c  = '{addr: ExpAddr, data: ExpData, pc: ExpPC};
   assign act_c  = '{addr: ActAddr, data: ActData, pc: ActPC};
   assign head_c = commit_t'(fifo_rdata);

   assign bypass  = fifo_empty && exp_acc && act_v;
   assign pop     = act_v && !fifo_empty;
   assign push    = exp_acc && !bypass;
   assign ovf_evt = push && fifo_full && !pop;

   commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (Clock),
      .rst_ni      (nReset),
      .push_i      (push),
      .wdata_i     (exp_c),
      .pop_i       (pop),
      .rdata_o     (fifo_rdata),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .full_next_o (fifo_full_next)
   );

   always_comb begin
      cmp_code = E_NONE;
      cmp_ref  = head_c;
      if (act_v) begin
         if (!fifo_empty) begin
            cmp_code = classify(head_c, act_c);
         end else if (exp_acc) begin
            cmp_ref  = exp_c;
            cmp_code = classify(exp_c, act_c);
         end else begin
            cmp_ref  = '0;
            cmp_code = E_UNEXP;
         end
      end
   end

   assign cmp_err   = (cmp_code != E_NONE);
   assign match_evt = act_v && !cmp_err;

   // Watchdog freezes after its single timeout event.
   always_comb begin
      tmo_evt = 1'b0;
      wd_d    = wd_q;
      if (!tmo_q) begin
         if (fifo_empty || act_v) begin
            wd_d = '0;
         end else begin
            wd_d    = wd_q + WD_W'(1);
            tmo_evt = (wd_q == WD_LAST);
         end
      end
   end

   assign n_err = {1'b0, cmp_err} + {1'b0, ovf_evt} + {1'b0, tmo_evt};

   always_comb begin
      evt_code = E_NONE;
      evt_addr = '0;
      evt_exp  = '0;
      evt_act  = '0;
      if (cmp_err) begin
         evt_code = cmp_code;
         evt_addr = cmp_ref.addr;
         evt_exp  = cmp_ref.data;
         evt_act  = ActData;
      end else if (ovf_evt) begin
         evt_code = E_OVF;
         evt_addr = ExpAddr;
         evt_exp  = ExpData;
      end else if (tmo_evt) begin
         evt_code = E_TMO;
         evt_addr = head_c.addr;
         evt_exp  = head_c.data;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (Drain) state_d = DRAIN;
         DRAIN:   if (fifo_empty || tmo_q) state_d = DONE;
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q    <= RUN;
         wd_q       <= '0;
         tmo_q      <= 1'b0;
         ovf_q      <= 1'b0;
         ready_q    <= 1'b0;
         pulse_q    <= 1'b0;
         match_q    <= '0;
         err_cnt_q  <= '0;
         err_code_q <= E_NONE;
         err_addr_q <= '0;
         err_exp_q  <= '0;
         err_act_q  <= '0;
      end else begin
         state_q   <= state_d;
         wd_q      <= wd_d;
         tmo_q     <= tmo_q || tmo_evt;
         ovf_q     <= ovf_q || ovf_evt;
         ready_q   <= !fifo_full_next;
         pulse_q   <= (evt_code != E_NONE);
         match_q   <= sat_add(match_q, {1'b0, match_evt});
         err_cnt_q <= sat_add(err_cnt_q, n_err);
         if (err_code_q == E_NONE && evt_code != E_NONE) begin
            err_code_q <= evt_code;
            err_addr_q <= evt_addr;
            err_exp_q  <= evt_exp;
            err_act_q  <= evt_act;
         end
      end
   end

   assign ExpReady = ready_q;
   assign MatchCnt = match_q;
   assign ErrCnt   = err_cnt_q;
   assign ErrPulse = pulse_q;
   assign ErrCode  = err_code_q;
   assign ErrAddr  = err_addr_q;
   assign ErrExp   = err_exp_q;
   assign ErrAct   = err_act_q;
   assign Done     = (state_q == DONE);
   assign Pass     = Done && (err_cnt_q == '0) && !ovf_q && !tmo_q;

endmodule
